// File: rtl/boundary_detector_gm.sv
// Time-multiplexed geometric-mean boundary detector: one shared multiply / bit-serial sqrt /
// alignment datapath sweeps NUM_CH boundaries and keeps per-channel stability and lock state.
module boundary_detector_gm #(
  parameter int WIDTH        = 18,
  parameter int FRAC         = 14,
  parameter int NUM_CH       = 3,
  parameter int SIGMA_LOG2   = 3,
  parameter int STAB_SHIFT   = 2,
  parameter int ALIGN_THRESH = 8192,
  parameter int DWELL_MIN    = 4,
  parameter int DWELL_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic [NUM_CH*WIDTH-1:0]  omega_a_in,
  input  logic [NUM_CH*WIDTH-1:0]  omega_b_in,
  input  logic [NUM_CH*WIDTH-1:0]  omega_ref_in,
  output logic [NUM_CH*WIDTH-1:0]  boundary_out,
  output logic [NUM_CH*WIDTH-1:0]  detuning_out,
  output logic [NUM_CH*WIDTH-1:0]  alignment_out,
  output logic [NUM_CH*WIDTH-1:0]  stability_out,
  output logic [NUM_CH-1:0]        locked_out,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW   = 2 * WIDTH;
  localparam int RW   = WIDTH + 2;
  localparam int SQ_W = 2 * SIGMA_LOG2;
  localparam int SH   = FRAC - SQ_W;

  localparam logic [WIDTH-1:0]   ONE_W       = WIDTH'(1) << FRAC;
  localparam logic [WIDTH-1:0]   THRESH_W    = WIDTH'(ALIGN_THRESH);
  localparam logic [RW-1:0]      SIGMA_W     = RW'(1) << SIGMA_LOG2;
  localparam logic [DWELL_W-1:0] DWELL_MAX   = '1;
  localparam logic [DWELL_W-1:0] DWELL_MIN_W = DWELL_W'(DWELL_MIN);
  localparam logic [CH_W-1:0]    LAST_CH     = CH_W'(NUM_CH - 1);
  localparam logic [PW-1:0]      TOP_BIT     = PW'(1) << (PW - 2);

  typedef enum logic [1:0] {IDLE, MUL, SQRT, ALIGN} state_t;

  state_t            state;
  logic [CH_W-1:0]   ch;

  logic signed [WIDTH-1:0] snap_a   [NUM_CH];
  logic signed [WIDTH-1:0] snap_b   [NUM_CH];
  logic signed [WIDTH-1:0] snap_ref [NUM_CH];

  // Digit-by-digit root: x holds the shrinking radicand, res the partial root, bit the one-hot weight.
  logic [PW-1:0] x_q, res_q, bit_q;

  logic signed [WIDTH-1:0] bnd_q [NUM_CH];
  logic signed [WIDTH-1:0] det_q [NUM_CH];
  logic signed [WIDTH-1:0] aln_q [NUM_CH];
  logic signed [WIDTH-1:0] stb_q [NUM_CH];
  logic [DWELL_W-1:0]      dwell_q [NUM_CH];
  logic [NUM_CH-1:0]       lock_q;

  logic signed [WIDTH-1:0] cur_a, cur_b, cur_ref;
  logic [WIDTH-1:0]        mag_a, mag_b, root_c, align_c;
  logic [PW-1:0]           prod_c, trial_c;
  logic                    sqrt_ge;
  logic signed [RW-1:0]    diff_c;
  logic [RW-1:0]           dist_c;
  logic [SQ_W-1:0]         dist_lo, dist_sq;
  logic signed [WIDTH:0]   stab_err;
  logic signed [WIDTH-1:0] stab_c;
  logic [DWELL_W-1:0]      dwell_c;

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    cur_a   = snap_a[ch];
    cur_b   = snap_b[ch];
    cur_ref = snap_ref[ch];
    mag_a   = cur_a;
    mag_b   = cur_b;
    prod_c  = '0;
    if (!cur_a[WIDTH-1] && cur_a != '0 && !cur_b[WIDTH-1] && cur_b != '0)
      prod_c = PW'(mag_a) * PW'(mag_b);

    trial_c = res_q + bit_q;
    sqrt_ge = x_q >= trial_c;
    root_c  = res_q[WIDTH-1:0];

    diff_c  = {2'b00, root_c} - {{2{cur_ref[WIDTH-1]}}, cur_ref};
    dist_c  = diff_c[RW-1] ? -diff_c : diff_c;
    dist_lo = SQ_W'(dist_c[SIGMA_LOG2-1:0]);
    dist_sq = dist_lo * dist_lo;
    align_c = '0;
    if (dist_c < SIGMA_W)
      align_c = ONE_W - (WIDTH'(dist_sq) << SH);

    stab_err = $signed({1'b0, align_c}) - $signed({stb_q[ch][WIDTH-1], stb_q[ch]});
    stab_c   = stb_q[ch] + WIDTH'(stab_err >>> STAB_SHIFT);

    dwell_c = '0;
    if (align_c >= THRESH_W)
      dwell_c = (dwell_q[ch] == DWELL_MAX) ? dwell_q[ch] : dwell_q[ch] + 1'b1;
  end

  // NOTE: the snapshot is always loaded before it is read, so it is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && clk_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        snap_a[i]   <= omega_a_in[i*WIDTH +: WIDTH];
        snap_b[i]   <= omega_b_in[i*WIDTH +: WIDTH];
        snap_ref[i] <= omega_ref_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch      <= '0;
      x_q     <= '0;
      res_q   <= '0;
      bit_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      lock_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        bnd_q[i]   <= '0;
        det_q[i]   <= '0;
        aln_q[i]   <= '0;
        stb_q[i]   <= '0;
        dwell_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (clk_en && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (clk_en) begin
            busy  <= 1'b1;
            ch    <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          x_q   <= prod_c;
          res_q <= '0;
          bit_q <= TOP_BIT;
          state <= SQRT;
        end
        SQRT: begin
          if (sqrt_ge) begin
            x_q   <= x_q - trial_c;
            res_q <= (res_q >> 1) + bit_q;
          end else begin
            res_q <= res_q >> 1;
          end
          bit_q <= bit_q >> 2;
          if (bit_q[0])
            state <= ALIGN;
        end
        ALIGN: begin
          bnd_q[ch]   <= root_c;
          det_q[ch]   <= dist_c[WIDTH-1:0];
          aln_q[ch]   <= align_c;
          stb_q[ch]   <= stab_c;
          dwell_q[ch] <= dwell_c;
          lock_q[ch]  <= dwell_c >= DWELL_MIN_W;
          if (ch == LAST_CH) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ch    <= ch + 1'b1;
            state <= MUL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign boundary_out[g*WIDTH +: WIDTH]  = bnd_q[g];
    assign detuning_out[g*WIDTH +: WIDTH]  = det_q[g];
    assign alignment_out[g*WIDTH +: WIDTH] = aln_q[g];
    assign stability_out[g*WIDTH +: WIDTH] = stb_q[g];
  end
  assign locked_out = lock_q;

endmodule

// File: tb/tb_boundary_detector_gm.sv
// Directed and randomized sweeps of boundary_detector_gm against an arithmetic reference model.
module tb_boundary_detector_gm;

  localparam int WIDTH        = 18;
  localparam int FRAC         = 14;
  localparam int NUM_CH       = 3;
  localparam int SIGMA_LOG2   = 3;
  localparam int STAB_SHIFT   = 2;
  localparam int ALIGN_THRESH = 8192;
  localparam int DWELL_MIN    = 4;
  localparam int DWELL_W      = 8;
  localparam int CYC          = WIDTH + 2;
  localparam int TOTAL        = NUM_CH * CYC;

  logic                    clk = 1'b0;
  logic                    rst_n, clk_en;
  logic [NUM_CH*WIDTH-1:0] omega_a_in, omega_b_in, omega_ref_in;
  logic [NUM_CH*WIDTH-1:0] boundary_out, detuning_out, alignment_out, stability_out;
  logic [NUM_CH-1:0]       locked_out;
  logic                    busy, done, overrun;

  boundary_detector_gm #(
    .WIDTH(WIDTH), .FRAC(FRAC), .NUM_CH(NUM_CH), .SIGMA_LOG2(SIGMA_LOG2),
    .STAB_SHIFT(STAB_SHIFT), .ALIGN_THRESH(ALIGN_THRESH), .DWELL_MIN(DWELL_MIN), .DWELL_W(DWELL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .omega_a_in(omega_a_in), .omega_b_in(omega_b_in), .omega_ref_in(omega_ref_in),
    .boundary_out(boundary_out), .detuning_out(detuning_out), .alignment_out(alignment_out),
    .stability_out(stability_out), .locked_out(locked_out),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int ta [NUM_CH];
  int tbv[NUM_CH];
  int tr [NUM_CH];
  int m_stab [NUM_CH];
  int m_dwell[NUM_CH];
  int e_bnd[NUM_CH], e_det[NUM_CH], e_aln[NUM_CH], e_stb[NUM_CH], e_lck[NUM_CH];
  int o_bnd[NUM_CH], o_stb[NUM_CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [WIDTH-1:0] field(input logic [NUM_CH*WIDTH-1:0] bus, input int k);
    return bus[k*WIDTH +: WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] mask(input int v);
    return v[WIDTH-1:0];
  endfunction

  function automatic longint isqrt(input longint v);
    longint lo = 0, hi = longint'(1) << 18, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_stab[k] = 0; m_dwell[k] = 0;
      e_bnd[k] = 0; e_det[k] = 0; e_aln[k] = 0; e_stb[k] = 0; e_lck[k] = 0;
    end
  endtask

  task automatic model_sweep();
    longint prod;
    int d;
    for (int k = 0; k < NUM_CH; k++) begin
      o_bnd[k] = e_bnd[k];
      o_stb[k] = e_stb[k];
      prod = (ta[k] > 0 && tbv[k] > 0) ? longint'(ta[k]) * longint'(tbv[k]) : 0;
      e_bnd[k] = int'(isqrt(prod));
      d = e_bnd[k] - tr[k];
      if (d < 0) d = -d;
      e_det[k] = d;
      e_aln[k] = (d >= (1 << SIGMA_LOG2)) ? 0 : (1 << FRAC) - d * d * (1 << (FRAC - 2*SIGMA_LOG2));
      m_stab[k] = m_stab[k] + ((e_aln[k] - m_stab[k]) >>> STAB_SHIFT);
      e_stb[k] = m_stab[k];
      if (e_aln[k] >= ALIGN_THRESH) begin
        if (m_dwell[k] < (1 << DWELL_W) - 1) m_dwell[k]++;
      end else begin
        m_dwell[k] = 0;
      end
      e_lck[k] = (m_dwell[k] >= DWELL_MIN) ? 1 : 0;
    end
  endtask

  task automatic apply_inputs();
    for (int k = 0; k < NUM_CH; k++) begin
      omega_a_in[k*WIDTH +: WIDTH]   = ta[k][WIDTH-1:0];
      omega_b_in[k*WIDTH +: WIDTH]   = tbv[k][WIDTH-1:0];
      omega_ref_in[k*WIDTH +: WIDTH] = tr[k][WIDTH-1:0];
    end
  endtask

  task automatic check_channel(input int k);
    check($sformatf("ch%0d_boundary", k), 64'(field(boundary_out, k)), 64'(mask(e_bnd[k])));
    check($sformatf("ch%0d_detuning", k), 64'(field(detuning_out, k)), 64'(mask(e_det[k])));
    check($sformatf("ch%0d_alignment", k), 64'(field(alignment_out, k)), 64'(mask(e_aln[k])));
    check($sformatf("ch%0d_stability", k), 64'(field(stability_out, k)), 64'(mask(e_stb[k])));
    check($sformatf("ch%0d_locked", k), 64'(locked_out[k]), 64'(e_lck[k]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_boundary"}, 64'(boundary_out), 64'(0));
    check({tag, "_detuning"}, 64'(detuning_out), 64'(0));
    check({tag, "_alignment"}, 64'(alignment_out), 64'(0));
    check({tag, "_stability"}, 64'(stability_out), 64'(0));
    check({tag, "_locked"}, 64'(locked_out), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_overrun"}, 64'(overrun), 64'(0));
  endtask

  // One full sweep; with disturb set, the buses are scrambled and clk_en is pulsed mid-sweep and at done.
  task automatic run_sweep(input bit disturb);
    int  n;
    bit  seen;
    model_sweep();
    apply_inputs();
    clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    check("busy_set", 64'(busy), 64'(1));
    n = 0;
    seen = 1'b0;
    while (!seen && n < TOTAL + 20) begin
      @(posedge clk); #1;
      n++;
      if (disturb) begin
        if (n == 5)
          for (int k = 0; k < NUM_CH; k++) begin
            omega_a_in[k*WIDTH +: WIDTH]   = WIDTH'($urandom());
            omega_b_in[k*WIDTH +: WIDTH]   = WIDTH'($urandom());
            omega_ref_in[k*WIDTH +: WIDTH] = WIDTH'($urandom());
          end
        if (n == 10 || n == TOTAL - 1) clk_en = 1'b1;
        if (n == 11 || n == TOTAL)     clk_en = 1'b0;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (n == (k + 1) * CYC - 1) begin
          check($sformatf("ch%0d_hold_boundary", k), 64'(field(boundary_out, k)), 64'(mask(o_bnd[k])));
          check($sformatf("ch%0d_hold_stability", k), 64'(field(stability_out, k)), 64'(mask(o_stb[k])));
        end
        if (n == (k + 1) * CYC) check_channel(k);
      end
      if (done) seen = 1'b1;
    end
    check("done_latency", 64'(n), 64'(TOTAL));
    check("busy_clear", 64'(busy), 64'(0));
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'(0));
    check("stays_idle", 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mode, bnd;
    clk_en = 1'b0;
    rst_n = 1'b0;
    omega_a_in = '0; omega_b_in = '0; omega_ref_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Reference-distance cases on all three channels.
    for (int k = 0; k < NUM_CH; k++) begin ta[k] = 410; tbv[k] = 664; end
    tr[0] = 514; tr[1] = 521; tr[2] = 530;
    run_sweep(1'b0);
    check("t1_boundary0", 64'(field(boundary_out, 0)), 64'(521));
    check("t1_detuning0", 64'(field(detuning_out, 0)), 64'(7));
    check("t1_alignment0", 64'(field(alignment_out, 0)), 64'(3840));
    check("t1_alignment1", 64'(field(alignment_out, 1)), 64'(16384));
    check("t1_detuning2", 64'(field(detuning_out, 2)), 64'(9));
    check("t1_alignment2", 64'(field(alignment_out, 2)), 64'(0));

    // Stability integration and dwell-qualified lock on ch0.
    do_reset();
    tr[0] = 521;
    for (int s = 0; s < 4; s++) begin
      run_sweep(1'b0);
      if (s == 0) check("stab_sweep1", 64'(field(stability_out, 0)), 64'(4096));
      if (s == 1) check("stab_sweep2", 64'(field(stability_out, 0)), 64'(7168));
      check($sformatf("lock_sweep%0d", s + 1), 64'(locked_out[0]), 64'(s == 3));
    end
    tr[0] = 514;
    run_sweep(1'b0);
    check("lock_drop", 64'(locked_out[0]), 64'(0));
    tr[0] = 521;
    run_sweep(1'b0);
    check("lock_dwell_cleared", 64'(locked_out[0]), 64'(0));

    // Non-positive operands and the largest positive product.
    ta[0] = -5;     tbv[0] = 664;    tr[0] = 514;
    ta[1] = 131071; tbv[1] = 131071; tr[1] = 131071;
    ta[2] = 0;      tbv[2] = 500;    tr[2] = 3;
    run_sweep(1'b0);
    check("neg_boundary0", 64'(field(boundary_out, 0)), 64'(0));
    check("neg_detuning0", 64'(field(detuning_out, 0)), 64'(514));
    check("neg_alignment0", 64'(field(alignment_out, 0)), 64'(0));
    check("max_boundary1", 64'(field(boundary_out, 1)), 64'(131071));
    check("zero_boundary2", 64'(field(boundary_out, 2)), 64'(0));

    // clk_en while busy and at done, plus bus changes mid-sweep.
    for (int k = 0; k < NUM_CH; k++) begin ta[k] = 410; tbv[k] = 664; end
    tr[0] = 514; tr[1] = 521; tr[2] = 530;
    check("overrun_before", 64'(overrun), 64'(0));
    run_sweep(1'b1);
    check("overrun_set", 64'(overrun), 64'(1));
    run_sweep(1'b0);
    check("overrun_sticky", 64'(overrun), 64'(1));

    // Randomized sweeps, mostly near-aligned so dwell and lock get exercised.
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        mode   = int'($urandom_range(0, 5));
        ta[k]  = int'($urandom_range(1, 120000));
        tbv[k] = int'($urandom_range(1, 120000));
        if (mode == 0) ta[k] = -int'($urandom_range(1, 131072));
        bnd = (ta[k] > 0) ? int'(isqrt(longint'(ta[k]) * longint'(tbv[k]))) : 0;
        tr[k] = (mode == 5) ? int'($urandom_range(0, 131071)) : bnd + int'($urandom_range(0, 12)) - 6;
      end
      run_sweep(1'b0);
    end

    // Reset in the middle of the square-root phase, then a clean sweep.
    for (int k = 0; k < NUM_CH; k++) begin ta[k] = 410; tbv[k] = 664; end
    tr[0] = 514; tr[1] = 521; tr[2] = 530;
    apply_inputs();
    clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all_zero("mid_reset");
    model_reset();
    run_sweep(1'b0);
    check("post_reset_boundary0", 64'(field(boundary_out, 0)), 64'(521));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
